data_memory_bhw: RTL and testbench

Parametrised RV32I data memory, successor to the word-only data memory. Supports byte, halfword and word loads and stores selected by funct3, with sign or zero extension on loads. Loads return data one cycle after the request. Misaligned accesses and illegal funct3 codes are flagged. Sits in the MEM stage, driven by the ALU address and the rs2 store data.

---
 rtl/data_memory_bhw.sv | 158 +++++++++++++++
 tb/tb_data_memory_bhw.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_bhw.sv
// RV32I data memory with byte/halfword/word access for the MEM stage.
// Loads are read synchronously and answered one cycle after the request;
// stores write only the addressed byte lanes. Misaligned accesses and
// unsupported funct3 codes are answered with err_o and have no side effect.
module data_memory_bhw #(
    parameter int ADDR_W    = 12,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              valid_o,
    output logic              err_o
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    // Access width as encoded in funct3[1:0]; funct3[2] selects zero-extension.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_NONE = 2'b11
    } size_e;

    localparam logic [31:0] INIT_WORD = INIT_ZERO ? 32'h0000_0000 : 32'hxxxx_xxxx;

    // NOTE: the array is never reset, so contents survive rst_i and the
    // storage maps onto block RAM; the declaration value only sets the
    // load-time image.
    logic [31:0] mem [DEPTH] = '{default: INIT_WORD};

    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        lane;
    size_e             size;
    logic              legal_f3;
    logic              misaligned;
    logic              req_err;
    logic              accept;
    logic              do_write;
    logic              do_read;
    logic [3:0]        byte_en;
    logic [31:0]       wdata;

    // Response pipeline state (one cycle behind the request).
    logic              valid_q;
    logic              err_q;
    logic              load_q;
    logic [2:0]        funct3_q;
    logic [1:0]        lane_q;
    logic [31:0]       rdata_q;

    assign word_idx = addr_i[ADDR_W-1:2];
    assign lane     = addr_i[1:0];
    assign size     = size_e'(funct3_i[1:0]);

    // Decode the request: legality, alignment, byte enables and lane-replicated write data.
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        legal_f3   = 1'b0;
        misaligned = 1'b0;
        byte_en    = 4'b0000;
        wdata      = data_i;

        if (we_i) begin
            legal_f3 = (funct3_i[2] == 1'b0) && (size != SZ_NONE);
        end else begin
            legal_f3 = (size != SZ_NONE) && !(funct3_i[2] && funct3_i[1]);
        end

        case (size)
            SZ_BYTE: begin
                byte_en = 4'b0001 << lane;
                wdata   = {4{data_i[7:0]}};
            end
            SZ_HALF: begin
                misaligned = lane[0];
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{data_i[15:0]}};
            end
            SZ_WORD: begin
                misaligned = (lane != 2'b00);
                byte_en    = 4'b1111;
                wdata      = data_i;
            end
            default: begin
                byte_en = 4'b0000;
                wdata   = data_i;
            end
        endcase
    end

    assign req_err  = !legal_f3 || misaligned;
    assign accept   = req_i && !rst_i;
    assign do_write = accept && we_i && !req_err;
    assign do_read  = accept && !we_i && !req_err;

    // Byte-lane writes and the registered word read for loads.
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (do_read) begin
            rdata_q <= mem[word_idx];
        end
    end

    // Response control: one valid pulse per accepted request, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            load_q   <= 1'b0;
            funct3_q <= 3'b000;
            lane_q   <= 2'b00;
        end else begin
            valid_q  <= req_i;
            err_q    <= req_i && req_err;
            load_q   <= do_read;
            funct3_q <= funct3_i;
            lane_q   <= lane;
        end
    end

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [31:0] load_val;

    // Extract and extend the addressed field of the read word.
    always_comb begin
        half_sel = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        byte_sel = lane_q[0] ? half_sel[15:8] : half_sel[7:0];
        load_val = 32'h0000_0000;
        case (funct3_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_val = rdata_q;
            3'b100:  load_val = {24'h000000, byte_sel};
            3'b101:  load_val = {16'h0000, half_sel};
            default: load_val = 32'h0000_0000;
        endcase
    end

    assign data_o  = load_q ? load_val : 32'h0000_0000;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_data_memory_bhw.sv
// Self-checking bench for data_memory_bhw: directed scenarios plus a
// randomized load/store stream checked against a byte-array model.
module tb_data_memory_bhw;

    localparam int ADDR_W = 12;
    localparam int NBYTES = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [2:0]        funct3 = 3'b000;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = 32'h0;
    logic [31:0]       data_o;
    logic              valid_o;
    logic              err_o;

    int checks = 0;
    int errors = 0;

    // Reference model: plain byte-addressed memory.
    logic [7:0] mdl [NBYTES];

    data_memory_bhw #(.ADDR_W(ADDR_W), .INIT_ZERO(1'b1)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .we_i     (we),
        .funct3_i (funct3),
        .addr_i   (addr),
        .data_i   (wdata),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    // Architectural behaviour of one access: returns the response and updates the model.
    task automatic model_access(input logic m_we, input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                                input logic [31:0] d, output logic [31:0] exp_d, output logic exp_e);
        int size;
        bit legal;
        longint val;
        size  = 0;
        legal = 0;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (m_we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else      legal = (size != 0);
        exp_d = 32'h0;
        exp_e = 1'b0;
        if (!legal || (int'(a) % size) != 0) begin
            exp_e = 1'b1;
        end else if (m_we) begin
            for (int i = 0; i < size; i++) mdl[int'(a) + i] = d[8*i +: 8];
        end else begin
            val = 0;
            for (int i = 0; i < size; i++) val = val + (longint'(mdl[int'(a) + i]) << (8 * i));
            if (f3 < 3'd4 && size < 4 && val >= (longint'(1) << (8 * size - 1)))
                val = val - (longint'(1) << (8 * size));
            exp_d = val[31:0];
        end
    endtask

    // Drive one request at the falling edge, let it be accepted, then check the response.
    task automatic issue(input logic i_we, input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                         input logic [31:0] d, input string name, output logic [31:0] got);
        logic [31:0] exp_d;
        logic        exp_e;
        model_access(i_we, f3, a, d, exp_d, exp_e);
        req = 1'b1; we = i_we; funct3 = f3; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        got = data_o;
        checks++;
        if (valid_o !== 1'b1) begin
            errors++;
            $display("FAIL %s valid: got %b expected 1", name, valid_o);
        end
        checks++;
        if (err_o !== exp_e) begin
            errors++;
            $display("FAIL %s err: got %b expected %b", name, err_o, exp_e);
        end
        checks++;
        if (data_o !== exp_d) begin
            errors++;
            $display("FAIL %s data: got %h expected %h", name, data_o, exp_d);
        end
    endtask

    task automatic expect_const(input logic [31:0] got, input logic [31:0] exp, input string name);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One cycle without a request: the response must be all zero.
    task automatic idle(input string name);
        req = 1'b0; we = $urandom_range(0, 1); funct3 = 3'($urandom); addr = ADDR_W'($urandom);
        wdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid_o, err_o, data_o} !== 34'h0) begin
            errors++;
            $display("FAIL %s idle: got valid=%b err=%b data=%h expected all zero",
                     name, valid_o, err_o, data_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid_o, err_o, data_o} !== 34'h0) begin
            errors++;
            $display("FAIL reset: got valid=%b err=%b data=%h expected all zero", valid_o, err_o, data_o);
        end
        rst = 1'b0;
        idle("after_reset");
    endtask

    task automatic test_word();
        logic [31:0] got;
        issue(1'b1, 3'b010, 12'h000, 32'h8765_43A1, "sw_000", got);
        issue(1'b0, 3'b010, 12'h000, 32'h0, "lw_000", got);
        expect_const(got, 32'h8765_43A1, "lw_000_const");
    endtask

    task automatic test_subword_loads();
        logic [31:0] got;
        issue(1'b0, 3'b000, 12'h000, 32'h0, "lb_000", got);
        expect_const(got, 32'hFFFF_FFA1, "lb_000_const");
        issue(1'b0, 3'b100, 12'h000, 32'h0, "lbu_000", got);
        expect_const(got, 32'h0000_00A1, "lbu_000_const");
        issue(1'b0, 3'b001, 12'h002, 32'h0, "lh_002", got);
        expect_const(got, 32'hFFFF_8765, "lh_002_const");
        issue(1'b0, 3'b101, 12'h002, 32'h0, "lhu_002", got);
        expect_const(got, 32'h0000_8765, "lhu_002_const");
        idle("subword_end");
    endtask

    task automatic test_partial_stores();
        logic [31:0] got;
        issue(1'b1, 3'b010, 12'h004, 32'h0000_0000, "sw_004", got);
        issue(1'b1, 3'b000, 12'h005, 32'hCCDD_EE5A, "sb_005", got);
        issue(1'b1, 3'b001, 12'h006, 32'h1234_BEEF, "sh_006", got);
        issue(1'b0, 3'b010, 12'h004, 32'h0, "lw_004", got);
        expect_const(got, 32'hBEEF_5A00, "lw_004_const");
        idle("partial_end");
    endtask

    task automatic test_errors();
        logic [31:0] got;
        issue(1'b1, 3'b010, 12'h008, 32'h1122_3344, "sw_008", got);
        issue(1'b0, 3'b010, 12'h002, 32'h0, "lw_misaligned", got);
        issue(1'b1, 3'b001, 12'h009, 32'h0000_FFFF, "sh_misaligned", got);
        issue(1'b0, 3'b010, 12'h008, 32'h0, "lw_008_unchanged", got);
        expect_const(got, 32'h1122_3344, "lw_008_const");
        issue(1'b0, 3'b011, 12'h000, 32'h0, "load_f3_011", got);
        issue(1'b1, 3'b100, 12'h008, 32'hFFFF_FFFF, "store_f3_100", got);
        issue(1'b1, 3'b101, 12'h008, 32'hFFFF_FFFF, "store_f3_101", got);
        issue(1'b0, 3'b110, 12'h008, 32'h0, "load_f3_110", got);
        issue(1'b0, 3'b001, 12'h00B, 32'h0, "lh_misaligned", got);
        issue(1'b0, 3'b010, 12'h008, 32'h0, "lw_008_after_errs", got);
        expect_const(got, 32'h1122_3344, "lw_008_const2");
        idle("errors_end");
    endtask

    // req held high for eight consecutive cycles; every issue checks valid_o=1.
    task automatic test_back_to_back();
        logic [31:0] got;
        issue(1'b1, 3'b010, 12'h00C, 32'd9010, "b2b_sw", got);
        expect_const(got, 32'h0, "b2b_sw_data");
        issue(1'b0, 3'b010, 12'h00C, 32'h0, "b2b_lw1", got);
        expect_const(got, 32'd9010, "b2b_lw1_const");
        issue(1'b1, 3'b000, 12'h00C, 32'h0000_007F, "b2b_sb", got);
        expect_const(got, 32'h0, "b2b_sb_data");
        issue(1'b0, 3'b010, 12'h00C, 32'h0, "b2b_lw2", got);
        expect_const(got, 32'h0000_237F, "b2b_lw2_const");
        issue(1'b1, 3'b001, 12'h00E, 32'h0000_1357, "b2b_sh", got);
        issue(1'b0, 3'b010, 12'h00C, 32'h0, "b2b_lw3", got);
        expect_const(got, 32'h1357_237F, "b2b_lw3_const");
        issue(1'b0, 3'b100, 12'h00F, 32'h0, "b2b_lbu", got);
        issue(1'b0, 3'b001, 12'h00E, 32'h0, "b2b_lh", got);
        idle("b2b_end");
    endtask

    // Known contents for the first 64 words, then a random mix of legal and faulting accesses.
    task automatic test_random();
        logic [31:0] got;
        for (int w = 0; w < 64; w++) issue(1'b1, 3'b010, 12'(w * 4), $urandom, "preload", got);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) idle("rand_idle");
            issue(1'($urandom_range(0, 1)), 3'($urandom), 12'($urandom_range(0, 255)), $urandom,
                  "random", got);
        end
        idle("random_end");
    endtask

    task automatic test_reset_drop();
        logic [31:0] got;
        issue(1'b1, 3'b010, 12'hFFC, 32'hCAFE_F00D, "sw_ffc", got);
        rst = 1'b1; req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 12'hFFC; wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({valid_o, err_o, data_o} !== 34'h0) begin
            errors++;
            $display("FAIL reset_drop during: got valid=%b err=%b data=%h expected all zero",
                     valid_o, err_o, data_o);
        end
        rst = 1'b0;
        idle("reset_drop_after");
        issue(1'b0, 3'b010, 12'hFFC, 32'h0, "lw_ffc", got);
        expect_const(got, 32'hCAFE_F00D, "lw_ffc_const");
        issue(1'b0, 3'b100, 12'hFFF, 32'h0, "lbu_fff", got);
        expect_const(got, 32'h0000_00CA, "lbu_fff_const");
        idle("final");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_word();
        test_subword_loads();
        test_partial_stores();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
